// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: latches trap CSRs, updates mstatus on
// trap entry / mret, and issues a one-cycle PC redirect while stalling the core.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic            time_compare,
  input  logic            sw_irq,
  input  logic            ext_irq,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            instr_done,
  input  logic [XLEN-1:0] next_pc,
  input  logic            mret,
  output logic [XLEN-1:0] mip,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mbadaddr,
  output logic            mstatus_we,
  output logic [XLEN-1:0] mstatus_wdata,
  output logic            busy,
  output logic            trap_req,
  output logic [XLEN-1:0] trap_pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_STATUS, S_REDIRECT, S_MRET
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mbad_q, mbad_d;

  logic [XLEN-1:0] irq_pend;
  logic            int_take;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] vec_off;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mip_q    <= '0;
      mcause_q <= '0;
      mepc_q   <= '0;
      mbad_q   <= '0;
    end else begin
      state_q  <= state_d;
      mip_q    <= mip_d;
      mcause_q <= mcause_d;
      mepc_q   <= mepc_d;
      mbad_q   <= mbad_d;
    end
  end

  always_comb begin
    mip_d     = '0;
    mip_d[11] = ext_irq;
    mip_d[7]  = time_compare;
    mip_d[3]  = sw_irq;
  end

  // Eligibility looks at the registered pending bits, so a level must be
  // visible in mip before the retiring instruction can take it.
  always_comb begin
    irq_pend = mie & mip_q;
    int_take = instr_done & mstatus[3] & (|irq_pend);
    if (irq_pend[11])     irq_code = 4'd11;
    else if (irq_pend[3]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
  end

  always_comb begin
    state_d  = state_q;
    mcause_d = mcause_q;
    mepc_d   = mepc_q;
    mbad_d   = mbad_q;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          state_d       = S_SAVE;
          mcause_d      = '0;
          mcause_d[3:0] = exc_code;
          mepc_d        = exc_pc;
          mbad_d        = exc_tval;
        end else if (int_take) begin
          state_d            = S_SAVE;
          mcause_d           = '0;
          mcause_d[3:0]      = irq_code;
          mcause_d[XLEN-1]   = 1'b1;
          mepc_d             = next_pc;
          mbad_d             = '0;
        end else if (mret) begin
          state_d = S_MRET;
        end
      end
      S_SAVE:   state_d = S_STATUS;
      S_STATUS: state_d = S_REDIRECT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by resetn so a reset landing mid-sequence suppresses
  // the mstatus write and redirect in that same cycle.
  always_comb begin
    busy          = 1'b0;
    mstatus_we    = 1'b0;
    mstatus_wdata = '0;
    trap_req      = 1'b0;
    trap_pc       = '0;
    tvec_base     = {mtvec[XLEN-1:2], 2'b00};
    vec_off       = {{(XLEN-6){1'b0}}, mcause_q[3:0], 2'b00};
    if (resetn) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_STATUS: begin
          mstatus_we       = 1'b1;
          mstatus_wdata    = mstatus;
          mstatus_wdata[7] = mstatus[3];
          mstatus_wdata[3] = 1'b0;
        end
        S_REDIRECT: begin
          trap_req = 1'b1;
          if (mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
            trap_pc = tvec_base + vec_off;
          else
            trap_pc = tvec_base;
        end
        S_MRET: begin
          mstatus_we       = 1'b1;
          mstatus_wdata    = mstatus;
          mstatus_wdata[3] = mstatus[7];
          mstatus_wdata[7] = 1'b1;
          trap_req         = 1'b1;
          trap_pc          = mepc_q;
        end
        default: ;
      endcase
    end
  end

  assign mip      = mip_q;
  assign mcause   = mcause_q;
  assign mepc     = mepc_q;
  assign mbadaddr = mbad_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a per-cycle timeline model checked every
// negedge, plus literal expectations at key points of each scenario.
module tb_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic [XLEN-1:0] mstatus, mie, mtvec;
  logic            time_compare, sw_irq, ext_irq;
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_pc, exc_tval, next_pc;
  logic            instr_done, mret;
  logic [XLEN-1:0] mip, mcause, mepc, mbadaddr, mstatus_wdata, trap_pc;
  logic            mstatus_we, busy, trap_req;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn), .mstatus(mstatus), .mie(mie), .mtvec(mtvec),
    .time_compare(time_compare), .sw_irq(sw_irq), .ext_irq(ext_irq),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .instr_done(instr_done), .next_pc(next_pc),
    .mret(mret), .mip(mip), .mcause(mcause), .mepc(mepc),
    .mbadaddr(mbadaddr), .mstatus_we(mstatus_we),
    .mstatus_wdata(mstatus_wdata), .busy(busy), .trap_req(trap_req),
    .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each cycle is described by a record; a trap entry schedules its
  // remaining cycles into a queue up front.
  typedef struct {
    bit              busy;
    bit              we;
    logic [XLEN-1:0] wd;
    bit              tr;
    logic [XLEN-1:0] pc;
  } rec_t;

  rec_t            cur;
  rec_t            sched[$];
  logic [XLEN-1:0] e_mip, e_mcause, e_mepc, e_mbad;
  bit              started = 0;

  function automatic rec_t idle_rec();
    rec_t r;
    r.busy = 0; r.we = 0; r.wd = '0; r.tr = 0; r.pc = '0;
    return r;
  endfunction

  always @(posedge clk) begin
    logic [XLEN-1:0] pend, base, new_mip;
    logic [3:0]      code;
    rec_t            r;
    bit              take;
    started = 1;
    new_mip = (ext_irq ? 32'h800 : 32'h0) | (time_compare ? 32'h80 : 32'h0) |
              (sw_irq ? 32'h8 : 32'h0);
    if (!resetn) begin
      cur = idle_rec(); sched.delete();
      e_mip = 0; e_mcause = 0; e_mepc = 0; e_mbad = 0;
    end else begin
      if (cur.busy) begin
        cur = (sched.size() > 0) ? sched.pop_front() : idle_rec();
      end else begin
        cur = idle_rec();
        pend = mie & e_mip & 32'h888;
        take = 0;
        if (exc_valid) begin
          e_mcause = {28'h0, exc_code}; e_mepc = exc_pc; e_mbad = exc_tval;
          take = 1;
        end else if (instr_done && mstatus[3] && pend != 0) begin
          code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
          e_mcause = 32'h8000_0000 + code; e_mepc = next_pc; e_mbad = 0;
          take = 1;
        end else if (mret) begin
          cur.busy = 1; cur.we = 1; cur.tr = 1; cur.pc = e_mepc;
          cur.wd = (mstatus & ~32'h88) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
        end
        if (take) begin
          cur.busy = 1;
          r = idle_rec(); r.busy = 1; r.we = 1;
          r.wd = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
          sched.push_back(r);
          base = mtvec & ~32'h3;
          r = idle_rec(); r.busy = 1; r.tr = 1;
          r.pc = (mtvec[1:0] == 2'b01 && e_mcause[31]) ? base + 4 * e_mcause[3:0] : base;
          sched.push_back(r);
        end
      end
      e_mip = new_mip;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mip", mip, e_mip);
      chk("mcause", mcause, e_mcause);
      chk("mepc", mepc, e_mepc);
      chk("mbadaddr", mbadaddr, e_mbad);
      chk("busy", {31'h0, busy}, {31'h0, resetn && cur.busy});
      chk("mstatus_we", {31'h0, mstatus_we}, {31'h0, resetn && cur.we});
      chk("trap_req", {31'h0, trap_req}, {31'h0, resetn && cur.tr});
      if (resetn && cur.we) chk("mstatus_wdata", mstatus_wdata, cur.wd);
      if (resetn && cur.tr) chk("trap_pc", trap_pc, cur.pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exc(input logic [3:0] c, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] tv);
    exc_valid = 1; exc_code = c; exc_pc = pc; exc_tval = tv;
  endtask

  initial begin
    resetn = 0; mstatus = 32'h8; mie = 0; mtvec = 0;
    time_compare = 0; sw_irq = 0; ext_irq = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
    instr_done = 0; next_pc = 0; mret = 0;

    // 1: reset with an exception pending
    set_exc(4'd2, 32'h100, 32'hDEAD);
    tick(); tick();
    chk("rst_mcause", mcause, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_trap_req", {31'h0, trap_req}, 32'h0);
    chk("rst_mip", mip, 32'h0);
    exc_valid = 0; resetn = 1;
    tick();

    // 2: exception entry
    mtvec = 32'h200; mstatus = 32'h8;
    set_exc(4'd2, 32'h100, 32'hDEAD);
    tick(); exc_valid = 0;
    chk("exc_mcause", mcause, 32'h2);
    chk("exc_mepc", mepc, 32'h100);
    chk("exc_mbad", mbadaddr, 32'hDEAD);
    tick();
    chk("exc_we", {31'h0, mstatus_we}, 32'h1);
    chk("exc_wdata", mstatus_wdata, 32'h80);
    tick();
    chk("exc_trap_req", {31'h0, trap_req}, 32'h1);
    chk("exc_trap_pc", trap_pc, 32'h200);
    tick();
    chk("exc_idle", {31'h0, busy}, 32'h0);

    // 4: ext beats sw; then masked by MIE=0
    mie = 32'h808; ext_irq = 1; sw_irq = 1;
    tick();
    chk("pri_mip", mip, 32'h808);
    instr_done = 1; next_pc = 32'h80;
    tick(); instr_done = 0;
    chk("pri_mcause", mcause, 32'h8000_000B);
    tick(); tick();
    chk("pri_trap_pc", trap_pc, 32'h200);
    tick();
    mstatus = 32'h0; instr_done = 1;
    tick();
    chk("mask_busy", {31'h0, busy}, 32'h0);
    chk("mask_mip", mip, 32'h808);
    instr_done = 0; ext_irq = 0; sw_irq = 0; mstatus = 32'h8;
    tick();

    // 3: vectored timer interrupt
    mtvec = 32'h401; mie = 32'h80; time_compare = 1;
    tick();
    instr_done = 1; next_pc = 32'h44;
    tick(); instr_done = 0;
    chk("vec_mcause", mcause, 32'h8000_0007);
    chk("vec_mepc", mepc, 32'h44);
    tick(); tick();
    chk("vec_trap_pc", trap_pc, 32'h41C);
    time_compare = 0;
    tick(); tick();

    // 5: mret, then exception beats mret
    mstatus = 32'h80; mret = 1;
    tick(); mret = 0;
    chk("mret_we", {31'h0, mstatus_we}, 32'h1);
    chk("mret_wdata", mstatus_wdata, 32'h88);
    chk("mret_trap_pc", trap_pc, 32'h44);
    tick();
    chk("mret_idle", {31'h0, busy}, 32'h0);
    mstatus = 32'h8; mret = 1; set_exc(4'd5, 32'h300, 32'h12);
    tick(); mret = 0; exc_valid = 0;
    chk("excmret_mcause", mcause, 32'h5);
    chk("excmret_mepc", mepc, 32'h300);
    tick(); tick();
    // exception held through REDIRECT is only taken once back in IDLE
    set_exc(4'd7, 32'h500, 32'h0);
    tick();
    chk("nest_busy", {31'h0, busy}, 32'h0);
    tick(); exc_valid = 0;
    chk("nest_mepc", mepc, 32'h500);
    chk("nest_mcause", mcause, 32'h7);
    tick(); tick(); tick();

    // 6: reset during STATUS
    set_exc(4'd1, 32'h600, 32'h4);
    tick(); exc_valid = 0;
    tick();
    resetn = 0;
    #1;
    chk("abort_we", {31'h0, mstatus_we}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    tick(); resetn = 1;
    chk("abort_mcause", mcause, 32'h0);
    tick();
    chk("abort_trap_req", {31'h0, trap_req}, 32'h0);
    chk("abort_busy2", {31'h0, busy}, 32'h0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
